key_expand_inv: RTL and testbench
=================================

# key_expand_inv

- Inverse AES-128 key schedule: takes the round-10 key as four serial 32-bit words and regenerates all 44 schedule words backward down to the original cipher key.
- Uses one word per clock.
- Feeds the decryption datapath, which consumes round keys in reverse order.
- Its readout interface (round number plus word index) matches key_expand, so either block can drive the round-key mux.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10, 44 words).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled on rising clk.
- last_key  input  32  round-10 key word; words w40..w43 in order on the four edges after start.
- r_index  input  2  word within a round key (0 = leftmost word).
- round_key_num  input  4  round number 0..10 to read.
- round_key  output  32  combinational read of word 4*round_key_num + r_index.
- done  output  1  schedule complete and readable.

## Operation
- **State machine.** States are IDLE, LOAD, EXPAND, DONE.
- **Reset (reset low).** State goes to IDLE, done=0, word counter=0, round_key=0.
- **IDLE.** On the edge where start=1: go to LOAD with load count 0.
  - Let S denote this edge.
- **LOAD.** last_key is stored into w[40+count] on edges S+1..S+4.
  - After the 4th word: state goes to EXPAND with i=43.
- **EXPAND.** One word per edge: w[i-4] = w[i] ^ t, then i decrements.
  - t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/4],24'h0} when i%4==0.
  - Otherwise t = w[i-1].
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- **EXPAND exit.** Runs 40 edges (i=43..4). After the edge writing w[0], state goes to DONE.
- **DONE.** done=1 and is held.
  - start=1 in DONE clears done on that edge and re-enters LOAD; same S timing as from IDLE.
- **start during LOAD or EXPAND.** Ignored; the sequence continues unchanged.
- **Readout (round_key).**
  - round_key = w[4*round_key_num + r_index] when done=1 and round_key_num<=10.
  - round_key = 0 when done=0 or round_key_num>10.
  - Purely combinational; no clock needed.
- **reset mid-LOAD or mid-EXPAND.** Aborts immediately; done=0. Partial store contents are never visible because readout is gated.

## Timing
- start sampled at edge S.
- Key words sampled at S+1, S+2, S+3, S+4.
- Expansion runs on edges S+5..S+44.
- done rises after edge S+44 (registered); latency is 44 cycles from the start edge.
- Round-key readout is valid in the same cycle the index changes, once done=1.
- All outputs are 0 out of reset.
- The S-box path is combinational within one cycle: four byte S-boxes plus XOR.

## Configuration
- **KEY_INV_ZEROIZE_EN defined:**
  - The 44×32 key store is asynchronously cleared by reset.
  - All entries are synchronously cleared on the start edge S, before loading.
  - No stale key material survives a restart or reset.
- **KEY_INV_ZEROIZE_EN undefined:**
  - The store has no reset and no clear, which saves area.
  - Stale contents remain internally but stay unreadable through the gated round_key.

## Structure
- aes_pkg holds:
  - the state enum (IDLE, LOAD, EXPAND, DONE);
  - the Rcon constant array;
  - NK=4, NR=10, NWORDS=44;
  - a rot_word function.
- Sub-module aes_sbox: byte-in/byte-out forward S-box, instantiated 4× for SubWord. It is shared with key_expand and the cipher datapath.

## Test plan
- **Reset.** Hold reset low 3 cycles -> done=0 and round_key=0 for every round_key_num and r_index.
- **FIPS-197 vector.** start, then d014f9a8 c9ee2589 e13f0cc8 b6630ca6 ->
  - done after exactly 44 cycles;
  - round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c;
  - round 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
- **"Thats my Kung Fu" vector.** start, then 28fddef8 6da4244a ccc0a4fe 3b316f26 ->
  - round 0 = 54686174 73206d79 204b756e 67204675;
  - round 10 reads back the loaded words.
- **Ignored start / restart.** Pulse start at cycle S+20 mid-EXPAND -> done still at S+44 with the same keys. Then pulse start in DONE with a new key -> done drops next cycle and new keys appear 44 cycles later.
- **Reset abort.** Assert reset at S+30, release, then rerun the FIPS vector -> done=0 during the abort, then correct keys. With KEY_INV_ZEROIZE_EN, a hierarchical peek of the store shows all zeros after reset.
- **Out-of-range read.** round_key_num=11..15 with done=1 -> round_key=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM states, round constants,
// schedule dimensions and the RotWord helper.
package aes_pkg;

  localparam int NK     = 4;
  localparam int NWORDS = 44;
  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Entry 0 is never used; the schedule indexes Rcon by i/4 for i = 4..40.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in and one byte out, purely combinational.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Table is stored MSB-first, so entry x sits at bits 2047-8x down.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[{~in_byte, 3'b111} -: 8];

endmodule

// File: rtl/key_expand_inv.sv
// Inverse AES-128 key schedule: rebuilds w[43..0] from the round-10 key.
// Optional KEY_INV_ZEROIZE_EN clears the key store on reset and on every start.
module key_expand_inv
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] last_key,
  input  logic [1:0]  r_index,
  input  logic [3:0]  round_key_num,
  output logic [31:0] round_key,
  output logic        done
);

  state_t      state;
  logic [5:0]  word_cnt;
  logic [31:0] key_store [0:NWORDS-1];

  logic        store_we;
  logic [5:0]  store_addr;
  logic [31:0] store_data;
  logic [31:0] cur_word;
  logic [31:0] prev_word;
  logic [31:0] rot_prev;
  logic [31:0] sub_prev;
  logic [31:0] tmp_word;
  logic [5:0]  rd_addr;
  logic        restart;

  assign cur_word  = key_store[word_cnt];
  assign prev_word = key_store[word_cnt - 6'd1];
  assign rot_prev  = rot_word(prev_word);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_prev[8*g +: 8]),
      .out_byte (sub_prev[8*g +: 8])
    );
  end

  assign tmp_word = (word_cnt[1:0] == 2'b00)
                    ? (sub_prev ^ {RCON[word_cnt[5:2]], 24'h0})
                    : prev_word;

  assign restart = start && ((state == IDLE) || (state == DONE));

  // LOAD fills w[40..43]; EXPAND walks backward writing w[i-4].
  always_comb begin
    store_we   = 1'b0;
    store_addr = 6'd0;
    store_data = 32'h0;
    case (state)
      LOAD: begin
        store_we   = 1'b1;
        store_addr = 6'(NWORDS - NK) + word_cnt;
        store_data = last_key;
      end
      EXPAND: begin
        store_we   = 1'b1;
        store_addr = word_cnt - 6'd4;
        store_data = cur_word ^ tmp_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_cnt <= 6'd0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            word_cnt <= 6'd0;
          end
        end
        LOAD: begin
          if (word_cnt == 6'd3) begin
            state    <= EXPAND;
            word_cnt <= 6'd43;
          end else begin
            word_cnt <= word_cnt + 6'd1;
          end
        end
        EXPAND: begin
          if (word_cnt == 6'd4) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            word_cnt <= word_cnt - 6'd1;
          end
        end
        DONE: begin
          if (start) begin
            state    <= LOAD;
            word_cnt <= 6'd0;
            done     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_INV_ZEROIZE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NWORDS; k++) key_store[k] <= 32'h0;
    end else if (restart) begin
      for (int k = 0; k < NWORDS; k++) key_store[k] <= 32'h0;
    end else if (store_we) begin
      key_store[store_addr] <= store_data;
    end
  end
`else
  // Without zeroize, restart only matters to the FSM; stale words stay hidden behind done.
  always_ff @(posedge clk) begin
    if (store_we) key_store[store_addr] <= store_data;
  end
`endif

  assign rd_addr   = {round_key_num, r_index};
  assign round_key = (done && (round_key_num <= NR)) ? key_store[rd_addr] : 32'h0;

endmodule

// File: tb/tb_key_expand_inv.sv
// Directed self-checking bench for key_expand_inv using FIPS-197 and
// "Thats my Kung Fu" schedules; peeks the store when KEY_INV_ZEROIZE_EN is set.
module tb_key_expand_inv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] last_key = 32'h0;
  logic [1:0]  r_index = 2'd0;
  logic [3:0]  round_key_num = 4'd0;
  logic [31:0] round_key;
  logic        done;

  int assert_count = 0;
  int fail_count   = 0;

  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_R0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KF_R10   = 128'h28fddef8_6da4244a_ccc0a4fe_3b316f26;
  localparam logic [127:0] KF_R1    = 128'he232fcf1_91129188_b159e4e6_d679a293;
  localparam logic [127:0] KF_R0    = 128'h54686174_73206d79_204b756e_67204675;

  key_expand_inv dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .last_key      (last_key),
    .r_index       (r_index),
    .round_key_num (round_key_num),
    .round_key     (round_key),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkRound(input string tag, input logic [3:0] rnd, input logic [127:0] exp);
    logic [127:0] e;
    e = exp;
    for (int r = 0; r < 4; r++) begin
      round_key_num = rnd;
      r_index       = 2'(r);
      #1;
      checkOutput($sformatf("%s_w%0d", tag, r), round_key, e[127-32*r -: 32]);
    end
  endtask

  // Start edge S, key words on S+1..S+4, then count to S+44; optional stray start at S+pulse_at.
  task automatic applyStimulus(input logic [127:0] key, input int pulse_at);
    logic [127:0] k;
    k = key;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("done_low_after_start", {31'h0, done}, 32'h0);
    for (int j = 0; j < 4; j++) begin
      last_key = k[127-32*j -: 32];
      @(posedge clk); #1;
    end
    last_key = 32'h0;
    for (int e = 5; e <= 43; e++) begin
      start = (e == pulse_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("done_before_44", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    checkOutput("done_at_44", {31'h0, done}, 32'h1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    for (int n = 0; n < 16; n++) begin
      for (int r = 0; r < 4; r++) begin
        round_key_num = 4'(n);
        r_index       = 2'(r);
        #1;
        checkOutput($sformatf("reset_rk_%0d_%0d", n, r), round_key, 32'h0);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] FIPS-197 vector");
    applyStimulus(FIPS_R10, 0);
    checkRound("fips_r0", 4'd0, FIPS_R0);
    checkRound("fips_r1", 4'd1, FIPS_R1);
    checkRound("fips_r2", 4'd2, FIPS_R2);
    checkRound("fips_r9", 4'd9, FIPS_R9);
    checkRound("fips_r10", 4'd10, FIPS_R10);

    $display("[TB] Out-of-range reads");
    for (int n = 11; n < 16; n++) begin
      round_key_num = 4'(n);
      r_index       = 2'(n % 4);
      #1;
      checkOutput($sformatf("oor_rk_%0d", n), round_key, 32'h0);
    end

    $display("[TB] Kung Fu vector from DONE");
    applyStimulus(KF_R10, 0);
    checkRound("kf_r0", 4'd0, KF_R0);
    checkRound("kf_r1", 4'd1, KF_R1);
    checkRound("kf_r10", 4'd10, KF_R10);

    $display("[TB] Stray start mid-EXPAND");
    applyStimulus(FIPS_R10, 20);
    checkRound("stray_r0", 4'd0, FIPS_R0);
    checkRound("stray_r1", 4'd1, FIPS_R1);

    $display("[TB] Restart in DONE");
    applyStimulus(KF_R10, 0);
    checkRound("restart_r0", 4'd0, KF_R0);

    $display("[TB] Reset abort");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      last_key = FIPS_R10[127-32*j -: 32];
      @(posedge clk); #1;
    end
    last_key = 32'h0;
    repeat (25) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_done", {31'h0, done}, 32'h0);
    round_key_num = 4'd0;
    r_index       = 2'd0;
    #1;
    checkOutput("abort_rk", round_key, 32'h0);
`ifdef KEY_INV_ZEROIZE_EN
    for (int k = 0; k < 44; k++) begin
      checkOutput($sformatf("zeroize_w%0d", k), dut.key_store[k], 32'h0);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_done_held", {31'h0, done}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(FIPS_R10, 0);
    checkRound("rerun_r0", 4'd0, FIPS_R0);
    checkRound("rerun_r1", 4'd1, FIPS_R1);
    checkRound("rerun_r10", 4'd10, FIPS_R10);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
